uart_rx_fifo: RTL

Receive-side byte FIFO between `uart_rx` and the CPU's UART data register.
- Captures each byte `uart_rx` delivers and holds it until the CPU reads it.
- Presents the head byte and status to the peripheral read mux.
- Drives flow control so the remote sender pauses before bytes are lost.
- Reports any loss through a sticky overflow flag.

---
 rtl/uart_rx_fifo.sv | 87 ++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the CPU data register.
// Holds received bytes, raises RTS to pause the sender, and flags dropped bytes.
module uart_rx_fifo #(
    parameter int DEPTH     = 8,
    parameter int RTS_LEVEL = 6
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wr_valid,
    input  logic [7:0]                 wr_data,
    input  logic                       rd_strobe,
    input  logic                       clr_overflow,
    output logic [7:0]                 rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       rts_stop
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] RTS_COUNT  = CW'(RTS_LEVEL);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wrEn;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);
    assign w_pop   = rd_strobe && !w_empty;
    // When full, a simultaneous pop frees the slot the write pointer already addresses.
    assign w_wrEn  = wr_valid && (!w_full || w_pop);
    assign w_drop  = wr_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_mem[r_wrPtr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_wrEn) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_wrEn, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign rd_data  = w_empty ? 8'h00 : r_mem[r_rdPtr];
    assign rd_valid = !w_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign rts_stop = (r_count >= RTS_COUNT);

endmodule
